ysyx_24080006_idu_q: RTL and testbench

- Next-generation RV32 decode stage between IFU and EXU.
- Replaces the single-entry IDLE/EXEC/WAIT handshake with a parametrised decoded-instruction queue, so full throughput (one instruction per cycle) is possible.
- Adds RV32E/RV32I register-count mode, illegal-instruction flagging in place of simulation abort, and a synchronous flush for redirects.
- Decode is combinational on the accepted instruction. Decoded bundles are enqueued and presented to the EXU in order.

---
 rtl/ysyx_24080006_idu_q.sv | 235 +++++++++++++++++++++++
 tb/tb_ysyx_24080006_idu_q.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_idu_q.sv
// RV32 decode stage with an in-order decoded-bundle queue.
// The IFU instruction is decoded combinationally in the cycle it is accepted.
// The resulting bundle is written at the queue tail. The EXU sees the head entry.
// Ports:
//   clock, reset (async, active-high), flush (sync discard of queue and input)
//   in_valid/in_ready/in_inst/in_pc     : IFU handshake
//   rs1_addr/rs2_addr, rs1_val/rs2_val  : same-cycle register-file read
//   csr_addr, csr_rdata                 : same-cycle CSR read
//   mepc_val/mepc_en                    : mepc capture on an accepted ecall
//   out_valid/out_ready, out_*          : head bundle towards the EXU
module ysyx_24080006_idu_q #(
  parameter int DEPTH = 2,
  parameter int NREG  = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic [31:0] mepc_val,
  output logic        mepc_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_src1,
  output logic [31:0] out_alu_src2,
  output logic [31:0] out_dnpc,
  output logic [31:0] out_sdata,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [31:0] out_csr_wdata,
  output logic [3:0]  out_alu_ctrl,
  output logic [1:0]  out_alu_set,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_rd,
  output logic [11:0] out_csr_addr,
  output logic        out_load,
  output logic        out_store,
  output logic        out_wb,
  output logic        out_jump,
  output logic        out_branch,
  output logic        out_ecall,
  output logic        out_ebreak,
  output logic        out_csr_we,
  output logic        out_illegal
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] alu_src1, alu_src2, dnpc, sdata, imm, pc, csr_wdata;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_set;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic        load, store, wb, jump, branch, ecall, ebreak, csr_we, illegal;
  } bundle_t;

  // ---------------- decode ----------------
  logic [6:0] opc;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_b, is_load, is_s, is_i, is_r, is_sys;
  logic is_ecall, is_mret, bad_reg;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t d;

  assign opc      = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_b     = (opc == 7'b1100011);
  assign is_load  = (opc == 7'b0000011);
  assign is_s     = (opc == 7'b0100011);
  assign is_i     = (opc == 7'b0010011);
  assign is_r     = (opc == 7'b0110011);
  assign is_sys   = (opc == 7'b1110011);
  assign is_ecall = (in_inst == 32'h0000_0073);
  assign is_mret  = (in_inst == 32'h3020_0073);

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign csr_addr = is_ecall ? 12'h305 : (is_mret ? 12'h341 : in_inst[31:20]);
  assign mepc_val = in_pc;

  function automatic logic reg_oob(input logic [4:0] idx);
    return (NREG < 32) && (int'(idx) >= NREG);
  endfunction

  // Register fields actually used by each format. The CSR immediate forms
  // (funct3[2]=1) carry a zimm in the rs1 slot, so that slot is not checked.
  always_comb begin
    bad_reg = 1'b0;
    if (is_r | is_i | is_load | is_jalr | is_lui | is_auipc | is_jal | is_sys)
      bad_reg = bad_reg | reg_oob(in_inst[11:7]);
    if (is_r | is_i | is_load | is_jalr | is_s | is_b | (is_sys & ~f3[2]))
      bad_reg = bad_reg | reg_oob(in_inst[19:15]);
    if (is_r | is_s | is_b)
      bad_reg = bad_reg | reg_oob(in_inst[24:20]);
  end

  always_comb begin
    d           = '0;
    d.pc        = in_pc;
    d.funct3    = f3;
    d.rd        = in_inst[11:7];
    d.csr_addr  = csr_addr;
    d.sdata     = rs2_val;
    d.csr_wdata = rs1_val;

    if (is_lui | is_auipc)                   d.imm = imm_u;
    else if (is_jal)                         d.imm = imm_j;
    else if (is_b)                           d.imm = imm_b;
    else if (is_s)                           d.imm = imm_s;
    else if (is_i | is_load | is_jalr | is_sys) d.imm = imm_i;

    if (is_jal | is_jalr | is_auipc) d.alu_src1 = in_pc;
    else if (is_lui)                 d.alu_src1 = 32'd0;
    else                             d.alu_src1 = rs1_val;

    if (is_lui | is_auipc | is_i | is_load | is_s) d.alu_src2 = d.imm;
    else if (is_b | is_r)                          d.alu_src2 = rs2_val;
    else if (is_jal | is_jalr)                     d.alu_src2 = 32'd4;
    else if (is_sys && f3 == 3'b010)               d.alu_src2 = csr_rdata;

    // Branches: beq/bne compare via subtract (10xx); lt/ltu use 00xx codes.
    if (is_b)                               d.alu_ctrl = {(f3[2:1] == 2'b00) ? 2'b10 : 2'b00, f3[2:1]};
    else if (is_r | (is_i && f3[1:0] == 2'b01)) d.alu_ctrl = {in_inst[30], f3};
    else if (is_i)                          d.alu_ctrl = {1'b0, f3};
    else if (is_sys && f3 == 3'b010)        d.alu_ctrl = 4'b0110;

    if (is_b) begin
      case (f3)
        3'b000:         d.alu_set = 2'b01;
        3'b001:         d.alu_set = 2'b10;
        3'b101, 3'b111: d.alu_set = 2'b11;
        default:        d.alu_set = 2'b00;
      endcase
    end

    if (is_jalr)     d.dnpc = (rs1_val + d.imm) & ~32'd1;
    else if (is_sys) d.dnpc = csr_rdata;
    else             d.dnpc = in_pc + d.imm;

    d.illegal = ~(is_b | is_i | is_r | is_s | is_load | is_jal | is_jalr |
                  is_lui | is_auipc | is_sys) | bad_reg;
    d.csr_we  = is_sys & (f3 != 3'b000) & ~d.illegal;
    d.jump    = (is_jal | is_jalr | (is_sys & (f3 == 3'b000))) & ~d.illegal;
    d.wb      = (is_auipc | is_lui | is_jal | is_jalr | is_i | is_r | is_load) & ~d.illegal;
    d.load    = is_load & ~d.illegal;
    d.store   = is_s & ~d.illegal;
    d.branch  = is_b & ~d.illegal;
    d.ecall   = is_ecall;
    d.ebreak  = (in_inst == 32'h0010_0073);
  end

  // ---------------- queue ----------------
  bundle_t            mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic               push, pop;
  bundle_t            hd;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign mepc_en   = push & is_ecall;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= d;
        tail      <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign hd            = mem[head];
  assign out_alu_src1  = hd.alu_src1;
  assign out_alu_src2  = hd.alu_src2;
  assign out_dnpc      = hd.dnpc;
  assign out_sdata     = hd.sdata;
  assign out_imm       = hd.imm;
  assign out_pc        = hd.pc;
  assign out_csr_wdata = hd.csr_wdata;
  assign out_alu_ctrl  = hd.alu_ctrl;
  assign out_alu_set   = hd.alu_set;
  assign out_funct3    = hd.funct3;
  assign out_rd        = hd.rd;
  assign out_csr_addr  = hd.csr_addr;
  assign out_load      = hd.load;
  assign out_store     = hd.store;
  assign out_wb        = hd.wb;
  assign out_jump      = hd.jump;
  assign out_branch    = hd.branch;
  assign out_ecall     = hd.ecall;
  assign out_ebreak    = hd.ebreak;
  assign out_csr_we    = hd.csr_we;
  assign out_illegal   = hd.illegal;
endmodule

// File: tb/tb_ysyx_24080006_idu_q.sv
module tb_ysyx_24080006_idu_q;
  logic clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0, rs1_val = '0, rs2_val = '0, csr_rdata = '0;

  logic in_ready, mepc_en, out_valid;
  logic [4:0] rs1_addr, rs2_addr, out_rd;
  logic [11:0] csr_addr, out_csr_addr;
  logic [31:0] mepc_val, out_alu_src1, out_alu_src2, out_dnpc, out_sdata, out_imm, out_pc, out_csr_wdata;
  logic [3:0] out_alu_ctrl;
  logic [1:0] out_alu_set;
  logic [2:0] out_funct3;
  logic out_load, out_store, out_wb, out_jump, out_branch, out_ecall, out_ebreak, out_csr_we, out_illegal;

  // RV32I instance driven in lockstep
  logic b_in_ready, b_mepc_en, b_out_valid;
  logic [4:0] b_rs1_addr, b_rs2_addr, b_rd;
  logic [11:0] b_csr_addr, b_out_csr_addr;
  logic [31:0] b_mepc_val, b_src1, b_src2, b_dnpc, b_sdata, b_imm, b_pc, b_csr_wdata;
  logic [3:0] b_ctrl;
  logic [1:0] b_set;
  logic [2:0] b_funct3;
  logic b_load, b_store, b_wb, b_jump, b_branch, b_ecall, b_ebreak, b_csr_we, b_illegal;

  always #5 clock = ~clock;

  ysyx_24080006_idu_q #(.DEPTH(2), .NREG(16)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .mepc_val(mepc_val), .mepc_en(mepc_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2), .out_dnpc(out_dnpc),
    .out_sdata(out_sdata), .out_imm(out_imm), .out_pc(out_pc), .out_csr_wdata(out_csr_wdata),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_set(out_alu_set), .out_funct3(out_funct3),
    .out_rd(out_rd), .out_csr_addr(out_csr_addr), .out_load(out_load), .out_store(out_store),
    .out_wb(out_wb), .out_jump(out_jump), .out_branch(out_branch), .out_ecall(out_ecall),
    .out_ebreak(out_ebreak), .out_csr_we(out_csr_we), .out_illegal(out_illegal));

  ysyx_24080006_idu_q #(.DEPTH(2), .NREG(32)) dut32 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .csr_addr(b_csr_addr), .csr_rdata(csr_rdata),
    .mepc_val(b_mepc_val), .mepc_en(b_mepc_en), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_alu_src1(b_src1), .out_alu_src2(b_src2), .out_dnpc(b_dnpc),
    .out_sdata(b_sdata), .out_imm(b_imm), .out_pc(b_pc), .out_csr_wdata(b_csr_wdata),
    .out_alu_ctrl(b_ctrl), .out_alu_set(b_set), .out_funct3(b_funct3),
    .out_rd(b_rd), .out_csr_addr(b_out_csr_addr), .out_load(b_load), .out_store(b_store),
    .out_wb(b_wb), .out_jump(b_jump), .out_branch(b_branch), .out_ecall(b_ecall),
    .out_ebreak(b_ebreak), .out_csr_we(b_csr_we), .out_illegal(b_illegal));

  // flags = {load, store, wb, jump, branch, ecall, ebreak, csr_we, illegal}
  typedef struct packed {
    logic [31:0] pc, src1, src2, dnpc;
    logic [3:0]  ctrl;
    logic [1:0]  set;
    logic [4:0]  rd;
    logic [8:0]  flags;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0;
  logic [8:0] out_flags;
  assign out_flags = {out_load, out_store, out_wb, out_jump, out_branch,
                      out_ecall, out_ebreak, out_csr_we, out_illegal};

  function automatic exp_t mk(input logic [31:0] pc, s1, s2, dn, input logic [3:0] c,
                              input logic [1:0] st, input logic [4:0] rd, input logic [8:0] fl);
    exp_t e;
    e.pc = pc; e.src1 = s1; e.src2 = s2; e.dnpc = dn;
    e.ctrl = c; e.set = st; e.rd = rd; e.flags = fl;
    return e;
  endfunction

  // addi x1,x0,5 at the given pc
  function automatic exp_t addi5(input logic [31:0] pc);
    return mk(pc, 32'd0, 32'd5, pc + 32'd5, 4'd0, 2'd0, 5'd1, 9'b001000000);
  endfunction

  // One clock cycle: drive inputs, sample at negedge against the scoreboard, advance.
  task automatic step(input logic v, input logic [31:0] inst, pc, r1, r2, csr,
                      input logic ordy, fl, input exp_t e);
    logic mready, push, pop;
    exp_t h;
    in_valid = v; in_inst = inst; in_pc = pc; rs1_val = r1; rs2_val = r2;
    csr_rdata = csr; out_ready = ordy; flush = fl;
    @(negedge clock);
    mready = (exp_q.size() < 2);
    push   = v & mready & ~fl;
    pop    = (exp_q.size() != 0) & ordy;
    checks++; if (in_ready !== mready) begin errors++; $display("FAIL in_ready got=%b exp=%b pc=%h", in_ready, mready, pc); end
    checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL out_valid got=%b exp=%b", out_valid, exp_q.size() != 0); end
    checks++; if (mepc_en !== (push & e.flags[3])) begin errors++; $display("FAIL mepc_en got=%b exp=%b", mepc_en, push & e.flags[3]); end
    if (v) begin
      checks++; if (rs1_addr !== inst[19:15] || rs2_addr !== inst[24:20]) begin errors++; $display("FAIL rs_addr got=%0d,%0d exp=%0d,%0d", rs1_addr, rs2_addr, inst[19:15], inst[24:20]); end
    end
    if (pop) begin
      h = exp_q.pop_front();
      checks++; if (out_pc !== h.pc) begin errors++; $display("FAIL head_pc got=%h exp=%h", out_pc, h.pc); end
      checks++; if (out_alu_src1 !== h.src1) begin errors++; $display("FAIL alu_src1 pc=%h got=%h exp=%h", h.pc, out_alu_src1, h.src1); end
      checks++; if (out_alu_src2 !== h.src2) begin errors++; $display("FAIL alu_src2 pc=%h got=%h exp=%h", h.pc, out_alu_src2, h.src2); end
      checks++; if (out_dnpc !== h.dnpc) begin errors++; $display("FAIL dnpc pc=%h got=%h exp=%h", h.pc, out_dnpc, h.dnpc); end
      checks++; if (out_alu_ctrl !== h.ctrl || out_alu_set !== h.set) begin errors++; $display("FAIL ctrl_set pc=%h got=%b/%b exp=%b/%b", h.pc, out_alu_ctrl, out_alu_set, h.ctrl, h.set); end
      checks++; if (out_rd !== h.rd) begin errors++; $display("FAIL rd pc=%h got=%0d exp=%0d", h.pc, out_rd, h.rd); end
      checks++; if (out_flags !== h.flags) begin errors++; $display("FAIL flags pc=%h got=%b exp=%b", h.pc, out_flags, h.flags); end
    end
    if (fl) exp_q.delete();
    else if (push) exp_q.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, '0);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (out_pc !== 32'd0 || out_dnpc !== 32'd0 || out_alu_src1 !== 32'd0 || out_flags !== 9'd0) begin errors++; $display("FAIL reset_out got pc=%h dnpc=%h flags=%b exp=0", out_pc, out_dnpc, out_flags); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    step(1'b1, 32'h00500093, 32'h80000000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, addi5(32'h80000000));
    step(1'b1, 32'h00208463, 32'h80000004, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0,
         mk(32'h80000004, 32'd5, 32'd7, 32'h8000000C, 4'b1000, 2'b01, 5'd8, 9'b000010000));
    idle(1'b1);
  endtask

  task automatic test_full;
    step(1'b1, 32'h00500093, 32'h100, 0, 0, 0, 1'b0, 1'b0, addi5(32'h100));
    step(1'b1, 32'h00500093, 32'h104, 0, 0, 0, 1'b0, 1'b0, addi5(32'h104));
    step(1'b1, 32'h00500093, 32'h108, 0, 0, 0, 1'b0, 1'b0, addi5(32'h108)); // refused
    step(1'b1, 32'h00500093, 32'h108, 0, 0, 0, 1'b1, 1'b0, addi5(32'h108)); // pop only
    step(1'b1, 32'h00500093, 32'h108, 0, 0, 0, 1'b1, 1'b0, addi5(32'h108)); // push+pop
    idle(1'b1);
  endtask

  task automatic test_jalr;
    step(1'b1, 32'h000280E7, 32'h80000100, 32'h80000011, 32'd0, 32'd0, 1'b0, 1'b0,
         mk(32'h80000100, 32'h80000100, 32'd4, 32'h80000010, 4'd0, 2'd0, 5'd1, 9'b001100000));
    idle(1'b1);
  endtask

  task automatic test_illegal;
    step(1'b1, 32'h00000833, 32'h80000200, 0, 0, 0, 1'b0, 1'b0,
         mk(32'h80000200, 32'd0, 32'd0, 32'h80000200, 4'd0, 2'd0, 5'd16, 9'b000000001));
    checks++; if (b_out_valid !== 1'b1 || b_illegal !== 1'b0 || b_wb !== 1'b1 || b_rd !== 5'd16) begin errors++; $display("FAIL rv32i_add got v=%b ill=%b wb=%b rd=%0d exp 1/0/1/16", b_out_valid, b_illegal, b_wb, b_rd); end
    idle(1'b1);
    step(1'b1, 32'h00000000, 32'h80000204, 0, 0, 0, 1'b0, 1'b0,
         mk(32'h80000204, 32'd0, 32'd0, 32'h80000204, 4'd0, 2'd0, 5'd0, 9'b000000001));
    checks++; if (b_illegal !== 1'b1 || b_wb !== 1'b0) begin errors++; $display("FAIL rv32i_badop got ill=%b wb=%b exp 1/0", b_illegal, b_wb); end
    idle(1'b1);
  endtask

  task automatic test_ecall_flush;
    step(1'b1, 32'h00000073, 32'h80000300, 0, 0, 32'h80000400, 1'b0, 1'b0,
         mk(32'h80000300, 32'd0, 32'd0, 32'h80000400, 4'd0, 2'd0, 5'd0, 9'b000101000));
    checks++; if (csr_addr !== 12'h305 || mepc_val !== 32'h80000300) begin errors++; $display("FAIL ecall_csr got=%h/%h exp=305/80000300", csr_addr, mepc_val); end
    step(1'b1, 32'h00500093, 32'h80000304, 0, 0, 0, 1'b1, 1'b0, addi5(32'h80000304));
    step(1'b1, 32'h00500093, 32'h80000308, 0, 0, 0, 1'b0, 1'b0, addi5(32'h80000308));
    // count is 2 here; flush with an ecall offered: nothing accepted, no mepc write
    step(1'b1, 32'h00000073, 32'h8000030C, 0, 0, 32'h80000400, 1'b0, 1'b1,
         mk(32'h8000030C, 32'd0, 32'd0, 32'h80000400, 4'd0, 2'd0, 5'd0, 9'b000101000));
    idle(1'b0);
    step(1'b1, 32'h00500093, 32'h80000500, 0, 0, 0, 1'b0, 1'b0, addi5(32'h80000500));
    idle(1'b1);
  endtask

  task automatic test_reset_mid;
    step(1'b1, 32'h00500093, 32'h200, 0, 0, 0, 1'b0, 1'b0, addi5(32'h200));
    step(1'b1, 32'h00500093, 32'h204, 0, 0, 0, 1'b0, 1'b0, addi5(32'h204));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got=%b/%b exp=0/1", out_valid, in_ready); end
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    step(1'b1, 32'h00500093, 32'h300, 0, 0, 0, 1'b0, 1'b0, addi5(32'h300));
    idle(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_jalr();
    test_illegal();
    test_ecall_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
